// File: rtl/draw_rect_ctl.sv
// Per-frame rectangle position controller: follows the mouse, then on a click drops
// the rectangle under gravity with damped floor bounces. Position steps once per vsync rising edge.
module draw_rect_ctl #(
  parameter int unsigned RECT_H  = 48,
  parameter int unsigned FLOOR_Y = 599,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned VMAX    = 31,
  parameter int unsigned VMIN    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        mouse_left,
  input  logic [10:0] mouse_xpos,
  input  logic [10:0] mouse_ypos,
  output logic [10:0] xpos_out,
  output logic [10:0] ypos_out,
  output logic [1:0]  state_out
);

  localparam int unsigned POS_W = 11;
  localparam int unsigned VEL_W = 6;
  localparam int unsigned YMAX  = FLOOR_Y + 1 - RECT_H;

  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    FALL   = 2'd1,
    RISE   = 2'd2,
    LANDED = 2'd3
  } state_t;

  state_t             r_state;
  logic [POS_W-1:0]   r_xpos;
  logic [POS_W-1:0]   r_ypos;
  logic [VEL_W-1:0]   r_v;
  logic               r_vsync_d;
  logic               r_left_d;

  state_t             w_state_nx;
  logic [POS_W-1:0]   w_xpos_nx;
  logic [POS_W-1:0]   w_ypos_nx;
  logic [VEL_W-1:0]   w_v_nx;

  logic               w_tick;
  logic               w_click;
  logic [VEL_W:0]     w_vsum;
  logic [VEL_W-1:0]   w_vn;
  logic [POS_W:0]     w_yt;
  logic [VEL_W-1:0]   w_vb;
  logic [POS_W-1:0]   w_mouse_y_clamped;

  assign w_tick  = vsync_in & ~r_vsync_d;
  assign w_click = mouse_left & ~r_left_d;

  // Falling-step arithmetic: saturated velocity, 12-bit trial position, damped bounce speed
  assign w_vsum = {1'b0, r_v} + (VEL_W+1)'(GRAVITY);
  assign w_vn   = (w_vsum > (VEL_W+1)'(VMAX)) ? VEL_W'(VMAX) : w_vsum[VEL_W-1:0];
  assign w_yt   = {1'b0, r_ypos} + (POS_W+1)'(w_vn);
  assign w_vb   = w_vn - (w_vn >> 2);

  assign w_mouse_y_clamped = (mouse_ypos > POS_W'(YMAX)) ? POS_W'(YMAX) : mouse_ypos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FOLLOW;
      r_xpos    <= '0;
      r_ypos    <= '0;
      r_v       <= '0;
      r_vsync_d <= 1'b1;
      r_left_d  <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_xpos    <= w_xpos_nx;
      r_ypos    <= w_ypos_nx;
      r_v       <= w_v_nx;
      r_vsync_d <= vsync_in;
      r_left_d  <= mouse_left;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_xpos_nx  = r_xpos;
    w_ypos_nx  = r_ypos;
    w_v_nx     = r_v;
    case (r_state)
      FOLLOW: begin
        w_xpos_nx = mouse_xpos;
        w_ypos_nx = w_mouse_y_clamped;
        w_v_nx    = '0;
        if (w_click) w_state_nx = FALL;
      end
      FALL: begin
        if (w_tick) begin
          if (w_yt >= (POS_W+1)'(YMAX)) begin
            w_ypos_nx = POS_W'(YMAX);
            if (w_vb < VEL_W'(VMIN)) begin
              w_v_nx     = '0;
              w_state_nx = LANDED;
            end else begin
              w_v_nx     = w_vb;
              w_state_nx = RISE;
            end
          end else begin
            w_ypos_nx = w_yt[POS_W-1:0];
            w_v_nx    = w_vn;
          end
        end
      end
      RISE: begin
        if (w_tick) begin
          // Ceiling: remaining upward speed would carry the sprite above line 0
          if (POS_W'(r_v) > r_ypos) begin
            w_ypos_nx  = '0;
            w_v_nx     = '0;
            w_state_nx = FALL;
          end else begin
            w_ypos_nx = r_ypos - POS_W'(r_v);
            if (r_v <= VEL_W'(GRAVITY)) begin
              w_v_nx     = '0;
              w_state_nx = FALL;
            end else begin
              w_v_nx = r_v - VEL_W'(GRAVITY);
            end
          end
        end
      end
      LANDED: begin
        if (w_click) w_state_nx = FOLLOW;
      end
      default: w_state_nx = FOLLOW;
    endcase
  end

  assign xpos_out  = r_xpos;
  assign ypos_out  = r_ypos;
  assign state_out = r_state;

endmodule
